// File: rtl/fpmul_arb_pkg.sv
// fpmul_arb_pkg: shared types and constants for the two-requester FP
// multiplier arbiter.
//   state_e        arbiter FSM encoding (IDLE/ISSUE/WAIT/DONE)
//   FLAG_*         bit positions inside the 6-bit {OF,UF,NaNF,InfF,DNF,ZF} flags
//   TIMEOUT_CYCLES WAIT cycles allowed before the watchdog gives up
//   QNAN           product reported for a timed-out operation
package fpmul_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam int unsigned FLAG_OF  = 5;
  localparam int unsigned FLAG_UF  = 4;
  localparam int unsigned FLAG_NAN = 3;
  localparam int unsigned FLAG_INF = 2;
  localparam int unsigned FLAG_DN  = 1;
  localparam int unsigned FLAG_Z   = 0;

  localparam int unsigned TIMEOUT_CYCLES = 31;
  localparam logic [31:0] QNAN           = 32'h7FC00000;
  localparam logic [5:0]  TIMEOUT_FLAGS  = 6'b000001 << FLAG_NAN;

endpackage

// File: rtl/fpmul_arb_rr.sv
// fpmul_arb_rr: 2-way round-robin picker.
//   req0_i, req1_i  request lines
//   last_i          requester served most recently
//   grant_o         chosen requester (valid only when valid_o is high)
//   valid_o         at least one request is pending
module fpmul_arb_rr (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic grant_o,
  output logic valid_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    // On a tie the requester that was not served last wins; otherwise
    // whichever one is asking.
    if (req0_i && req1_i) begin
      grant_o = ~last_i;
    end else begin
      grant_o = req1_i;
    end
  end

endmodule

// File: rtl/fpmul_arb.sv
// fpmul_arb: arbitrates two requesters onto one shared FP multiplier.
//   Clk, Rst            clock, synchronous active-high reset
//   Req0/Req1, A*/B*    requests and IEEE-754 single operands
//   Ack0/Ack1           one-cycle completion pulse per requester
//   Res, Flags          captured product and {OF,UF,NaNF,InfF,DNF,ZF}
//   TimeoutF            high with Ack when the watchdog expired
//   Busy                high whenever not IDLE
//   MA, MB, MStart, MRst, MP, MFlags, MDone   multiplier interface
// Optional feature: define FPMUL_ARB_TIMEOUT_EN to bound WAIT with a
// 5-bit watchdog; otherwise WAIT is unbounded and TimeoutF is 0.
module fpmul_arb
  import fpmul_arb_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req0,
  input  logic        Req1,
  input  logic [31:0] A0,
  input  logic [31:0] B0,
  input  logic [31:0] A1,
  input  logic [31:0] B1,
  output logic        Ack0,
  output logic        Ack1,
  output logic [31:0] Res,
  output logic [5:0]  Flags,
  output logic        TimeoutF,
  output logic        Busy,
  output logic [31:0] MA,
  output logic [31:0] MB,
  output logic        MStart,
  output logic        MRst,
  input  logic [31:0] MP,
  input  logic [5:0]  MFlags,
  input  logic        MDone
);

  state_e      state_q, state_d;
  logic        last_q,  last_d;
  logic        gnt_q,   gnt_d;
  logic [31:0] ma_q,    ma_d;
  logic [31:0] mb_q,    mb_d;
  logic [31:0] res_q,   res_d;
  logic [5:0]  flags_q, flags_d;
  logic        rr_grant, rr_valid;

`ifdef FPMUL_ARB_TIMEOUT_EN
  logic        tout_q, tout_d;
  logic [4:0]  wdog_q, wdog_d;
`endif

  fpmul_arb_rr u_rr (
    .req0_i  (Req0),
    .req1_i  (Req1),
    .last_i  (last_q),
    .grant_o (rr_grant),
    .valid_o (rr_valid)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
`ifdef FPMUL_ARB_TIMEOUT_EN
      tout_q  <= 1'b0;
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      res_q   <= res_d;
      flags_q <= flags_d;
`ifdef FPMUL_ARB_TIMEOUT_EN
      tout_q  <= tout_d;
      wdog_q  <= wdog_d;
`endif
    end
  end

  // Next-state and datapath capture
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    res_d   = res_q;
    flags_d = flags_q;
`ifdef FPMUL_ARB_TIMEOUT_EN
    tout_d  = tout_q;
    wdog_d  = wdog_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          gnt_d   = rr_grant;
          last_d  = rr_grant;
          ma_d    = rr_grant ? A1 : A0;
          mb_d    = rr_grant ? B1 : B0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
`ifdef FPMUL_ARB_TIMEOUT_EN
        wdog_d  = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (MDone) begin
          res_d   = MP;
          flags_d = MFlags;
`ifdef FPMUL_ARB_TIMEOUT_EN
          tout_d  = 1'b0;
`endif
          state_d = ST_DONE;
        end
`ifdef FPMUL_ARB_TIMEOUT_EN
        // wdog_q counts completed WAIT cycles, so this fires on the 31st.
        else if (wdog_q == 5'(TIMEOUT_CYCLES - 1)) begin
          res_d   = QNAN;
          flags_d = TIMEOUT_FLAGS;
          tout_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          wdog_d  = wdog_q + 5'd1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs; strobes are masked by Rst so nothing fires in a reset cycle.
  always_comb begin
    Busy     = (state_q != ST_IDLE) && !Rst;
    MStart   = (state_q == ST_ISSUE) && !Rst;
    Ack0     = (state_q == ST_DONE) && !gnt_q && !Rst;
    Ack1     = (state_q == ST_DONE) && gnt_q && !Rst;
    MRst     = Rst || (state_q == ST_DONE);
`ifdef FPMUL_ARB_TIMEOUT_EN
    TimeoutF = (state_q == ST_DONE) && tout_q && !Rst;
`else
    TimeoutF = 1'b0;
`endif
    Res      = res_q;
    Flags    = flags_q;
    MA       = ma_q;
    MB       = mb_q;
  end

endmodule

// File: doc/fpmul_arb.md
FPMUL_ARB -- requirements
Module: fpmul_arb

Interface
REQ-001 Clk  in  1  Sole clock; all state updates on its rising edge.
REQ-002 Rst  in  1  Synchronous, active-high reset.
REQ-003 Req0 / Req1  in  1  Requester N wants a multiply; held high until AckN.
REQ-004 A0, B0 / A1, B1  in  32  Requester N operands, IEEE-754 single; stable while ReqN is high.
REQ-005 Ack0 / Ack1  out  1  One-cycle pulse: Res/Flags are valid for requester N.
REQ-006 Res  out  32  Captured product, shared by both requesters, valid while AckN is high.
REQ-007 Flags  out  6  Captured {OF,UF,NaNF,InfF,DNF,ZF}, bit 5 down to bit 0.
REQ-008 TimeoutF  out  1  High with AckN when the operation timed out.
REQ-009 Busy  out  1  High in every state except IDLE.
REQ-010 MA, MB  out  32  Operands driven to the multiplier.
REQ-011 MStart  out  1  Multiplier Start.
REQ-012 MRst  out  1  Multiplier Rst; clears the multiplier's sticky Done.
REQ-013 MP  in  32  Multiplier product.
REQ-014 MFlags  in  6  Multiplier flags, same order as Flags.
REQ-015 MDone  in  1  Multiplier Done; sticky until MRst.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE:
  - Any ReqN high: grant one requester, latch its A/B into MA/MB, go ISSUE.
  - Otherwise stay in IDLE.
REQ-018 ISSUE: MStart=1 for exactly this one cycle, then go WAIT.
REQ-019 WAIT: on the first cycle MDone is sampled high, register MP into Res and MFlags into Flags, then go DONE.
REQ-020 DONE, one cycle:
  - AckN=1 for the granted requester only.
  - MRst=1.
  - Then go IDLE.
REQ-021 Arbitration is 2-way round-robin.
  - A single requester is granted immediately.
  - When both request, the one not served last wins.
  - The last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-022 Latency is 3 cycles plus the multiplier latency: Ack comes exactly one cycle after MDone is first sampled high.
REQ-023 Res and Flags hold their values after Ack until the next capture.
REQ-024 Requester handshake:
  - The requester drops ReqN in the cycle after AckN.
  - A ReqN still high in IDLE counts as a new request.
REQ-025 A ReqN that changes while the other requester is being served has no effect on the operation in flight.
REQ-026 MDone high during IDLE or ISSUE is ignored.
REQ-027 MStart is never high in the same cycle as MRst.

Reset
REQ-028 Rst, including mid-operation:
  - State goes to IDLE and the round-robin pointer to 1.
  - Ack0, Ack1, MStart, Busy, TimeoutF go to 0.
  - Res, Flags, MA, MB go to 0.
  - No Ack is issued for an aborted operation.
REQ-029 MRst = Rst OR (state == DONE), so the multiplier is reset together with the arbiter.

Configuration
REQ-030 With FPMUL_ARB_TIMEOUT_EN defined, a 5-bit watchdog runs:
  - It clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches 31 with MDone still low: Res=32'h7FC00000, Flags=6'b001000 (NaNF), TimeoutF=1, then go DONE (Ack and MRst as usual).
  - On a normal completion, TimeoutF=0.
REQ-031 Without FPMUL_ARB_TIMEOUT_EN: WAIT has no bound, the watchdog is absent, and TimeoutF is tied to 0.

Structure
REQ-032 Package fpmul_arb_pkg holds:
  - State enum.
  - Flag bit-index constants.
  - TIMEOUT_CYCLES = 31.
  - QNAN = 32'h7FC00000.
REQ-033 The round-robin picker is sub-module fpmul_arb_rr: inputs Req0/Req1 and last-served pointer; outputs grant and grant-valid.

Verification
REQ-034 Single request: Req0, A0=32'h40000000, B0=32'h40400000; multiplier model returns MP=32'h40C00000 with MDone 5 cycles after MStart.
  - Ack0 pulses one cycle after MDone; Res=32'h40C00000.
  - Ack1 never pulses.
REQ-035 Simultaneous requests: Req0 and Req1 high from the same cycle after reset.
  - Order of service is 0 then 1; each gets exactly one Ack.
  - Both keep requesting: grants alternate 0,1,0,1.
REQ-036 Flag capture: model returns MFlags=6'b100000 with MP=32'h7F800000.
  - Flags=6'b100000 and Res=32'h7F800000 during the Ack.
  - MRst is high in the Ack cycle.
REQ-037 Reset mid-operation: assert Rst in the third WAIT cycle.
  - No Ack; Busy=0 and MRst=1 in the reset cycle.
  - A new Req1 afterwards completes normally.
REQ-038 Timeout (macro on): model never raises MDone.
  - After 31 WAIT cycles, Ack0 with Res=32'h7FC00000, Flags=6'b001000, TimeoutF=1.
  - With the macro off, Busy stays 1 and no Ack occurs for 100 cycles.
